// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU opcodes,
// the controller state type and an opcode legality helper.
package alu_pkg;

  localparam int W_DEF   = 32;
  localparam int OPW_DEF = 4;

  localparam logic [OPW_DEF-1:0] OP_AND = 4'b0000;
  localparam logic [OPW_DEF-1:0] OP_OR  = 4'b0001;
  localparam logic [OPW_DEF-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW_DEF-1:0] OP_SUB = 4'b0110;
  localparam logic [OPW_DEF-1:0] OP_SLT = 4'b0111;
  localparam logic [OPW_DEF-1:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // True for the six codes the shared ALU implements; anything else is
  // answered with a zero result and the error flag.
  function automatic logic is_legal_op(input logic [OPW_DEF-1:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: grants the only valid requester, or on a tie
// the one that did not win last time.
module rr_pick2
  import alu_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Pick the winner from the current valids and the previous winner.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    gnt_valid_o = |valid_i;
    gnt_id_o    = 1'b0;
    if (valid_i == 2'b11) begin
      gnt_id_o = ~last_i;
    end else if (valid_i[1]) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU. Each accepted
// operation runs IDLE -> EXEC -> RESP; the result is registered and held
// for the consumer until it is taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           reset,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_in1,
  input  logic [W-1:0]   req0_in2,
  input  logic [OPW-1:0] req0_op,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_in1,
  input  logic [W-1:0]   req1_in2,
  input  logic [OPW-1:0] req1_op,

  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic [OPW-1:0] alu_ctrl,
  input  logic [W-1:0]   alu_res,

  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_res,
  output logic           rsp_zero,
  output logic           rsp_err
);

  state_e         state_q;
  logic           last_grant_q;

  logic [W-1:0]   in1_q;
  logic [W-1:0]   in2_q;
  logic [OPW-1:0] op_q;
  logic           id_q;

  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [W-1:0]   rsp_res_q;
  logic           rsp_zero_q;
  logic           rsp_err_q;

  logic           gnt_valid;
  logic           gnt_id;
  logic           accept;
  logic           legal_d;
  logic [W-1:0]   res_d;

  rr_pick2 u_pick (
    .valid_i     ({req1_valid, req0_valid}),
    .last_i      (last_grant_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // A requester is ready only while idle and holding the grant, so at most
  // one ready is ever high and ready implies that requester is valid.
  assign req0_ready = (state_q == IDLE) && gnt_valid && !gnt_id;
  assign req1_ready = (state_q == IDLE) && gnt_valid &&  gnt_id;
  assign accept     = req0_ready || req1_ready;

  // Illegal opcodes are answered with zero regardless of what the ALU says.
  assign legal_d = is_legal_op(op_q);
  assign res_d   = legal_d ? alu_res : '0;

  // Drive the shared ALU only while executing; park its inputs at zero
  // otherwise.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_ctrl = '0;
    if (state_q == EXEC) begin
      alu_in1  = in1_q;
      alu_in2  = in2_q;
      alu_ctrl = op_q;
    end
  end

  // Capture the granted requester's operation on the accept edge.
  // NOTE: these operand registers have no reset; they are only observed in
  // EXEC, which can only be entered through an accept that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      in1_q <= gnt_id ? req1_in1 : req0_in1;
      in2_q <= gnt_id ? req1_in2 : req0_in2;
      op_q  <= gnt_id ? req1_op  : req0_op;
      id_q  <= gnt_id;
    end
  end

  // Controller: accept, execute for one cycle, then hold the response.
  // Reset wins over any same-cycle accept or response handshake.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_grant_q <= gnt_id;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_res_q   <= res_d;
          rsp_zero_q  <= (res_d == '0);
          rsp_err_q   <= !legal_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_alu_arbiter;

  localparam int W   = 32;
  localparam int OPW = 4;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
  } txn_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_in1, req0_in2, req1_in1, req1_in2;
  logic [OPW-1:0] req0_op, req1_op;
  logic [W-1:0]   alu_in1, alu_in2, alu_res;
  logic [OPW-1:0] alu_ctrl;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0]   rsp_res;

  // Requester side stimulus.
  txn_t req     [2];
  logic r_valid [2];

  assign req0_valid = r_valid[0];
  assign req1_valid = r_valid[1];
  assign req0_in1   = req[0].a;
  assign req0_in2   = req[0].b;
  assign req0_op    = req[0].op;
  assign req1_in1   = req[1].a;
  assign req1_in2   = req[1].b;
  assign req1_op    = req[1].op;

  logic [OPW-1:0] legal_ops [6] = '{4'b0010, 4'b0110, 4'b0000,
                                   4'b0001, 4'b1100, 4'b0111};

  // Model state: m_age < 0 means no operation in flight, 0 is the cycle
  // after acceptance, >= 1 means the response is being presented.
  int       m_age;
  logic     m_last;
  logic     m_cur_id;
  txn_t     m_cur;
  logic [W-1:0] m_res;
  logic     m_after_reset;
  logic     drop_pend;
  logic     drop_id;
  int       refill_pct;
  logic     rnd_rsp;
  logic     rnd_reset;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_op    (req1_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_ctrl   (alu_ctrl),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  // The bench plays the shared ALU; unknown codes return a non-zero marker
  // so that the arbiter's forcing of illegal results to zero is visible.
  function automatic logic [W-1:0] golden(input logic [OPW-1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return ~(a | b);
      4'b0111: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic legal(input logic [OPW-1:0] op);
    return op inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  endfunction

  always_comb alu_res = golden(alu_ctrl, alu_in1, alu_in2);

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    k = $urandom_range(0, 7);
    if (k < 6)       t.op = legal_ops[k];
    else if (k == 6) t.op = 4'b1111;
    else             t.op = 4'($urandom);
    t.a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
    t.b = ($urandom_range(0, 3) == 0) ? t.a : W'($urandom);
    return t;
  endfunction

  function automatic txn_t mk(input logic [OPW-1:0] op,
                              input logic [W-1:0] a,
                              input logic [W-1:0] b);
    txn_t t;
    t.op = op;
    t.a  = a;
    t.b  = b;
    return t;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Entered just after a falling edge with inputs set;
  // checks all outputs, advances the model on the rising edge, and applies
  // the next inputs at the following falling edge.
  task automatic step();
    logic idle, e_rdy0, e_rdy1, exec;
    #1;
    idle   = (m_age < 0);
    exec   = (m_age == 0);
    e_rdy0 = idle && r_valid[0] && (!r_valid[1] ||  m_last);
    e_rdy1 = idle && r_valid[1] && (!r_valid[0] || !m_last);

    check("req0_ready", W'(req0_ready), W'(e_rdy0));
    check("req1_ready", W'(req1_ready), W'(e_rdy1));
    check("alu_in1",    alu_in1,        exec ? m_cur.a : '0);
    check("alu_in2",    alu_in2,        exec ? m_cur.b : '0);
    check("alu_ctrl",   W'(alu_ctrl),   exec ? W'(m_cur.op) : '0);
    check("rsp_valid",  W'(rsp_valid),  W'(m_age >= 1));
    if (m_age >= 1) begin
      check("rsp_id",   W'(rsp_id),   W'(m_cur_id));
      check("rsp_res",  rsp_res,      m_res);
      check("rsp_zero", W'(rsp_zero), W'(m_res == '0));
      check("rsp_err",  W'(rsp_err),  W'(!legal(m_cur.op)));
    end else if (m_after_reset) begin
      check("rst_id",   W'(rsp_id),   '0);
      check("rst_res",  rsp_res,      '0);
      check("rst_zero", W'(rsp_zero), '0);
      check("rst_err",  W'(rsp_err),  '0);
    end

    @(posedge clk);
    if (reset) begin
      m_age         = -1;
      m_last        = 1'b1;
      m_after_reset = 1'b1;
    end else if (m_age < 0) begin
      if (e_rdy0 || e_rdy1) begin
        m_cur_id  = e_rdy1;
        m_cur     = req[int'(e_rdy1)];
        m_res     = legal(m_cur.op) ? golden(m_cur.op, m_cur.a, m_cur.b) : '0;
        m_last    = e_rdy1;
        m_age     = 0;
        drop_pend = 1'b1;
        drop_id   = e_rdy1;
      end
    end else if (m_age == 0) begin
      m_age         = 1;
      m_after_reset = 1'b0;
    end else if (rsp_ready) begin
      m_age = -1;
    end else begin
      m_age++;
    end

    @(negedge clk);
    if (drop_pend) begin
      r_valid[int'(drop_id)] = 1'b0;
      drop_pend = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (!r_valid[i] && ($urandom_range(1, 100) <= refill_pct)) begin
        req[i]     = rand_txn();
        r_valid[i] = 1'b1;
      end
    end
    if (rnd_rsp)   rsp_ready = ($urandom_range(0, 3) != 0);
    if (rnd_reset) reset     = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    reset      = 1'b1;
    rsp_ready  = 1'b0;
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    req[0]     = '0;
    req[1]     = '0;
    refill_pct = 0;
    rnd_rsp    = 1'b0;
    rnd_reset  = 1'b0;
    drop_pend  = 1'b0;
    drop_id    = 1'b0;
    m_cur      = '0;
    m_cur_id   = 1'b0;
    m_res      = '0;
    repeat (2) @(posedge clk);
    m_age         = -1;
    m_last        = 1'b1;
    m_after_reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    rsp_ready = 1'b1;

    // Quiet cycles straight out of reset.
    repeat (2) step();

    // req0 add 5,7 alone.
    req[0] = mk(4'b0010, 32'd5, 32'd7);
    r_valid[0] = 1'b1;
    repeat (4) step();

    // req1 sub 9,9 gives a zero result.
    req[1] = mk(4'b0110, 32'd9, 32'd9);
    r_valid[1] = 1'b1;
    repeat (4) step();

    // Illegal opcode from req0.
    req[0] = mk(4'b1111, 32'd3, 32'd4);
    r_valid[0] = 1'b1;
    repeat (4) step();

    // Consumer stalls for five cycles in RESP while req0 waits.
    req[1] = mk(4'b0001, 32'd1, 32'd2);
    r_valid[1] = 1'b1;
    step();
    rsp_ready = 1'b0;
    req[0] = mk(4'b1100, 32'd0, 32'd0);
    r_valid[0] = 1'b1;
    repeat (6) step();
    rsp_ready = 1'b1;
    repeat (5) step();

    // Both requesters busy continuously after reset: grants alternate.
    reset = 1'b1;
    step();
    reset      = 1'b0;
    refill_pct = 100;
    repeat (12) step();

    // Reset during EXEC discards the operation; next tie goes to req0.
    refill_pct = 0;
    reset      = 1'b1;
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    step();
    reset  = 1'b0;
    req[0] = mk(4'b0010, 32'd1, 32'd1);
    r_valid[0] = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    req[0] = mk(4'b0111, 32'hFFFF_FFFF, 32'd1);
    req[1] = mk(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    r_valid[0] = 1'b1;
    r_valid[1] = 1'b1;
    repeat (8) step();

    // Randomized traffic with random back-pressure and occasional resets.
    refill_pct = 50;
    rnd_rsp    = 1'b1;
    rnd_reset  = 1'b1;
    repeat (500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
